// File: rtl/dual_issue_operand_bypass.sv
// -----------------------------------------------------------------------------
// dual_issue_operand_bypass
//
// Purpose:
//   Operand forwarding and ID/EX pipeline register for a two-wide decode
//   bundle. Each slot's source operands are selected from the EX, MEM or WB
//   result or from the register file, and are registered into the ID/EX
//   stage. Two hazards cannot be resolved by forwarding, and both stall the
//   bundle:
//   - load-use: a load in EX has no data yet.
//   - intra-bundle dependency: slot 2 reads slot 1's destination.
//   A dependency is handled by issuing slot 1 alone and then slot 2 on a
//   later cycle (SPLIT state).
//
// Handshake (valid/ready):
//   The decode bundle is offered while id_valid is high. It is consumed in
//   every cycle where id_valid && id_ready is true, and id_ready is
//   combinational. A flush also raises id_ready, so the bundle is discarded.
//   ex_ready low freezes every ID/EX register and the FSM state.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   id_valid / id_ready        decode bundle handshake
//   dec_*_num_{1,2}            slot register numbers
//   {a,b,c}_forward_{1,2}      forwarding codes (bit0 = src1, bit1 = src2)
//   rf_rs{1,2}_data_{1,2}      register-file read data
//   ex/mem/wb_result           bypass sources
//   ex_is_load, ex_ready, flush
//   ex_valid_{1,2}, ex_op{1,2}_{1,2}, ex_dst_{1,2}   ID/EX register outputs
//   split_pending              debug view of the FSM: high in SPLIT
// -----------------------------------------------------------------------------
module dual_issue_operand_bypass #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [4:0]      dec_dstreg_num_1,
   input  logic [4:0]      dec_srcreg1_num_1,
   input  logic [4:0]      dec_srcreg2_num_1,
   input  logic [4:0]      dec_dstreg_num_2,
   input  logic [4:0]      dec_srcreg1_num_2,
   input  logic [4:0]      dec_srcreg2_num_2,
   input  logic [1:0]      a_forward_1,
   input  logic [1:0]      b_forward_1,
   input  logic [1:0]      c_forward_1,
   input  logic [1:0]      a_forward_2,
   input  logic [1:0]      b_forward_2,
   input  logic [1:0]      c_forward_2,
   input  logic [XLEN-1:0] rf_rs1_data_1,
   input  logic [XLEN-1:0] rf_rs2_data_1,
   input  logic [XLEN-1:0] rf_rs1_data_2,
   input  logic [XLEN-1:0] rf_rs2_data_2,
   input  logic [XLEN-1:0] ex_result,
   input  logic [XLEN-1:0] mem_result,
   input  logic [XLEN-1:0] wb_result,
   input  logic            ex_is_load,
   input  logic            ex_ready,
   input  logic            flush,
   output logic            ex_valid_1,
   output logic            ex_valid_2,
   output logic [XLEN-1:0] ex_op1_1,
   output logic [XLEN-1:0] ex_op2_1,
   output logic [XLEN-1:0] ex_op1_2,
   output logic [XLEN-1:0] ex_op2_2,
   output logic [4:0]      ex_dst_1,
   output logic [4:0]      ex_dst_2,
   output logic            split_pending
);

   typedef enum logic {ISSUE = 1'b0, SPLIT = 1'b1} state_e;

   state_e          state_q, state_d;
   logic            ex_valid_1_q, ex_valid_1_d;
   logic            ex_valid_2_q, ex_valid_2_d;
   logic [XLEN-1:0] ex_op1_1_q, ex_op1_1_d;
   logic [XLEN-1:0] ex_op2_1_q, ex_op2_1_d;
   logic [XLEN-1:0] ex_op1_2_q, ex_op1_2_d;
   logic [XLEN-1:0] ex_op2_2_q, ex_op2_2_d;
   logic [4:0]      ex_dst_1_q, ex_dst_1_d;
   logic [4:0]      ex_dst_2_q, ex_dst_2_d;

   logic [XLEN-1:0] fwd_op1_1, fwd_op2_1, fwd_op1_2, fwd_op2_2;
   logic            dep, lu1, lu2;

   // Forwarding muxes: the most recent stage wins (EX, then MEM, then WB).
   always_comb begin
      fwd_op1_1 = a_forward_1[0] ? ex_result : b_forward_1[0] ? mem_result :
                  c_forward_1[0] ? wb_result : rf_rs1_data_1;
      fwd_op2_1 = a_forward_1[1] ? ex_result : b_forward_1[1] ? mem_result :
                  c_forward_1[1] ? wb_result : rf_rs2_data_1;
      fwd_op1_2 = a_forward_2[0] ? ex_result : b_forward_2[0] ? mem_result :
                  c_forward_2[0] ? wb_result : rf_rs1_data_2;
      fwd_op2_2 = a_forward_2[1] ? ex_result : b_forward_2[1] ? mem_result :
                  c_forward_2[1] ? wb_result : rf_rs2_data_2;
   end

   // x0 is hardwired, so writing it never creates a dependency.
   assign dep = (dec_dstreg_num_1 != 5'd0) &&
                ((dec_srcreg1_num_2 == dec_dstreg_num_1) ||
                 (dec_srcreg2_num_2 == dec_dstreg_num_1));
   // A load in EX only has data from MEM onward, so any EX-stage match stalls.
   assign lu1 = ex_is_load && (a_forward_1 != 2'b00);
   assign lu2 = ex_is_load && (a_forward_2 != 2'b00);

   always_comb begin
      state_d      = state_q;
      ex_valid_1_d = ex_valid_1_q;
      ex_valid_2_d = ex_valid_2_q;
      ex_op1_1_d   = ex_op1_1_q;
      ex_op2_1_d   = ex_op2_1_q;
      ex_op1_2_d   = ex_op1_2_q;
      ex_op2_2_d   = ex_op2_2_q;
      ex_dst_1_d   = ex_dst_1_q;
      ex_dst_2_d   = ex_dst_2_q;
      id_ready     = 1'b0;

      if (flush) begin
         ex_valid_1_d = 1'b0;
         ex_valid_2_d = 1'b0;
         state_d      = ISSUE;
         id_ready     = 1'b1;
      end else if (ex_ready) begin
         ex_valid_1_d = 1'b0;
         ex_valid_2_d = 1'b0;
         case (state_q)
            ISSUE: begin
               // A slot-2 load-use hazard that is also dependent is resolved
               // in SPLIT, where slot 2's codes are re-evaluated.
               if (id_valid && !(lu1 || (lu2 && !dep))) begin
                  ex_valid_1_d = 1'b1;
                  ex_op1_1_d   = fwd_op1_1;
                  ex_op2_1_d   = fwd_op2_1;
                  ex_dst_1_d   = dec_dstreg_num_1;
                  if (dep) begin
                     state_d = SPLIT;
                  end else begin
                     ex_valid_2_d = 1'b1;
                     ex_op1_2_d   = fwd_op1_2;
                     ex_op2_2_d   = fwd_op2_2;
                     ex_dst_2_d   = dec_dstreg_num_2;
                     id_ready     = 1'b1;
                  end
               end
            end
            SPLIT: begin
               // The bundle is held; slot 1 now sits in EX and slot 2's
               // forwarding codes already point at it.
               if (!lu2) begin
                  ex_valid_2_d = 1'b1;
                  ex_op1_2_d   = fwd_op1_2;
                  ex_op2_2_d   = fwd_op2_2;
                  ex_dst_2_d   = dec_dstreg_num_2;
                  id_ready     = 1'b1;
                  state_d      = ISSUE;
               end
            end
            default: state_d = ISSUE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ISSUE;
         ex_valid_1_q <= 1'b0;
         ex_valid_2_q <= 1'b0;
         ex_op1_1_q   <= '0;
         ex_op2_1_q   <= '0;
         ex_op1_2_q   <= '0;
         ex_op2_2_q   <= '0;
         ex_dst_1_q   <= '0;
         ex_dst_2_q   <= '0;
      end else begin
         state_q      <= state_d;
         ex_valid_1_q <= ex_valid_1_d;
         ex_valid_2_q <= ex_valid_2_d;
         ex_op1_1_q   <= ex_op1_1_d;
         ex_op2_1_q   <= ex_op2_1_d;
         ex_op1_2_q   <= ex_op1_2_d;
         ex_op2_2_q   <= ex_op2_2_d;
         ex_dst_1_q   <= ex_dst_1_d;
         ex_dst_2_q   <= ex_dst_2_d;
      end
   end

   assign ex_valid_1    = ex_valid_1_q;
   assign ex_valid_2    = ex_valid_2_q;
   assign ex_op1_1      = ex_op1_1_q;
   assign ex_op2_1      = ex_op2_1_q;
   assign ex_op1_2      = ex_op1_2_q;
   assign ex_op2_2      = ex_op2_2_q;
   assign ex_dst_1      = ex_dst_1_q;
   assign ex_dst_2      = ex_dst_2_q;
   assign split_pending = (state_q == SPLIT);

endmodule

// File: tb/tb_dual_issue_operand_bypass.sv
// -----------------------------------------------------------------------------
// tb_dual_issue_operand_bypass
//
// Directed bench for dual_issue_operand_bypass. Inputs are driven 1 ns after
// the rising edge. Registered outputs are checked 1 ns after the edge that
// captures them, and id_ready is checked before that edge.
// -----------------------------------------------------------------------------
module tb_dual_issue_operand_bypass;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            id_valid, id_ready;
   logic [4:0]      dst_1, s1_1, s2_1, dst_2, s1_2, s2_2;
   logic [1:0]      a_1, b_1, c_1, a_2, b_2, c_2;
   logic [XLEN-1:0] rs1_1, rs2_1, rs1_2, rs2_2;
   logic [XLEN-1:0] ex_result, mem_result, wb_result;
   logic            ex_is_load, ex_ready, flush;
   logic            ex_valid_1, ex_valid_2, split_pending;
   logic [XLEN-1:0] ex_op1_1, ex_op2_1, ex_op1_2, ex_op2_2;
   logic [4:0]      ex_dst_1, ex_dst_2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_issue_operand_bypass #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
      .dec_dstreg_num_1(dst_1), .dec_srcreg1_num_1(s1_1), .dec_srcreg2_num_1(s2_1),
      .dec_dstreg_num_2(dst_2), .dec_srcreg1_num_2(s1_2), .dec_srcreg2_num_2(s2_2),
      .a_forward_1(a_1), .b_forward_1(b_1), .c_forward_1(c_1),
      .a_forward_2(a_2), .b_forward_2(b_2), .c_forward_2(c_2),
      .rf_rs1_data_1(rs1_1), .rf_rs2_data_1(rs2_1),
      .rf_rs1_data_2(rs1_2), .rf_rs2_data_2(rs2_2),
      .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
      .ex_is_load(ex_is_load), .ex_ready(ex_ready), .flush(flush),
      .ex_valid_1(ex_valid_1), .ex_valid_2(ex_valid_2),
      .ex_op1_1(ex_op1_1), .ex_op2_1(ex_op2_1),
      .ex_op1_2(ex_op1_2), .ex_op2_2(ex_op2_2),
      .ex_dst_1(ex_dst_1), .ex_dst_2(ex_dst_2),
      .split_pending(split_pending)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_valid = 1'b0; ex_is_load = 1'b0; ex_ready = 1'b1; flush = 1'b0;
      dst_1 = 5'd1; s1_1 = 5'd2; s2_1 = 5'd3;
      dst_2 = 5'd4; s1_2 = 5'd6; s2_2 = 5'd7;
      a_1 = 2'b00; b_1 = 2'b00; c_1 = 2'b00;
      a_2 = 2'b00; b_2 = 2'b00; c_2 = 2'b00;
      rs1_1 = 32'h99; rs2_1 = 32'h99; rs1_2 = 32'h99; rs2_2 = 32'h99;
      ex_result = 32'h0; mem_result = 32'h0; wb_result = 32'h0;
   endtask

   // Withdraw the bundle and let one empty cycle drain the valids.
   task automatic drain();
      clear_inputs();
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #2;
      checks++; if ({ex_valid_1, ex_valid_2, split_pending} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b exp 000", {ex_valid_1, ex_valid_2, split_pending}); end
      checks++; if ({ex_op1_1, ex_op2_1, ex_op1_2, ex_op2_2} !== 128'h0) begin
         errors++; $display("FAIL reset_ops got %h exp 0", {ex_op1_1, ex_op2_1, ex_op1_2, ex_op2_2}); end
      checks++; if ({ex_dst_1, ex_dst_2} !== 10'h0) begin
         errors++; $display("FAIL reset_dst got %h exp 0", {ex_dst_1, ex_dst_2}); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_independent();
      id_valid = 1'b1;
      a_1 = 2'd1; b_1 = 2'd0; c_1 = 2'd2;
      a_2 = 2'd0; b_2 = 2'd2; c_2 = 2'd1;
      ex_result = 32'h11; mem_result = 32'h22; wb_result = 32'h33;
      #1;
      checks++; if (id_ready !== 1'b1) begin
         errors++; $display("FAIL indep_id_ready got %b exp 1", id_ready); end
      tick();
      checks++; if ({ex_valid_1, ex_valid_2} !== 2'b11) begin
         errors++; $display("FAIL indep_valids got %b exp 11", {ex_valid_1, ex_valid_2}); end
      checks++; if ({ex_op1_1, ex_op2_1} !== {32'h11, 32'h33}) begin
         errors++; $display("FAIL indep_slot1_ops got %h %h exp 11 33", ex_op1_1, ex_op2_1); end
      checks++; if ({ex_op1_2, ex_op2_2} !== {32'h33, 32'h22}) begin
         errors++; $display("FAIL indep_slot2_ops got %h %h exp 33 22", ex_op1_2, ex_op2_2); end
      checks++; if ({ex_dst_1, ex_dst_2} !== {5'd1, 5'd4}) begin
         errors++; $display("FAIL indep_dst got %0d %0d exp 1 4", ex_dst_1, ex_dst_2); end
      drain();
      checks++; if ({ex_valid_1, ex_valid_2} !== 2'b00) begin
         errors++; $display("FAIL idle_valids got %b exp 00", {ex_valid_1, ex_valid_2}); end
   endtask

   task automatic test_intra_dep();
      id_valid = 1'b1;
      dst_1 = 5'd5; s1_2 = 5'd8; s2_2 = 5'd5; dst_2 = 5'd9;
      rs1_1 = 32'h101; rs2_1 = 32'h102;
      #1;
      checks++; if (id_ready !== 1'b0) begin
         errors++; $display("FAIL dep_id_ready_c1 got %b exp 0", id_ready); end
      tick();
      checks++; if ({ex_valid_1, ex_valid_2, split_pending} !== 3'b101) begin
         errors++; $display("FAIL dep_c1_flags got %b exp 101", {ex_valid_1, ex_valid_2, split_pending}); end
      checks++; if ({ex_op1_1, ex_dst_1} !== {32'h101, 5'd5}) begin
         errors++; $display("FAIL dep_c1_slot1 got %h %0d exp 101 5", ex_op1_1, ex_dst_1); end
      checks++; if (ex_op1_2 !== 32'h33) begin
         errors++; $display("FAIL dep_c1_slot2_hold got %h exp 33", ex_op1_2); end
      a_2 = 2'd2; ex_result = 32'hAB; rs1_2 = 32'h201;
      #1;
      checks++; if (id_ready !== 1'b1) begin
         errors++; $display("FAIL dep_id_ready_c2 got %b exp 1", id_ready); end
      tick();
      checks++; if ({ex_valid_1, ex_valid_2, split_pending} !== 3'b010) begin
         errors++; $display("FAIL dep_c2_flags got %b exp 010", {ex_valid_1, ex_valid_2, split_pending}); end
      checks++; if ({ex_op1_2, ex_op2_2, ex_dst_2} !== {32'h201, 32'hAB, 5'd9}) begin
         errors++; $display("FAIL dep_c2_slot2 got %h %h %0d exp 201 ab 9", ex_op1_2, ex_op2_2, ex_dst_2); end
      checks++; if (ex_op1_1 !== 32'h101) begin
         errors++; $display("FAIL dep_c2_slot1_hold got %h exp 101", ex_op1_1); end
      drain();
   endtask

   task automatic test_dst_zero();
      id_valid = 1'b1;
      dst_1 = 5'd0; s1_2 = 5'd0; s2_2 = 5'd0;
      #1;
      checks++; if (id_ready !== 1'b1) begin
         errors++; $display("FAIL x0_id_ready got %b exp 1", id_ready); end
      tick();
      checks++; if ({ex_valid_1, ex_valid_2, split_pending} !== 3'b110) begin
         errors++; $display("FAIL x0_flags got %b exp 110", {ex_valid_1, ex_valid_2, split_pending}); end
      drain();
   endtask

   task automatic test_load_use();
      id_valid = 1'b1; ex_is_load = 1'b1; a_1 = 2'd1;
      #1;
      checks++; if (id_ready !== 1'b0) begin
         errors++; $display("FAIL lu_id_ready_bubble got %b exp 0", id_ready); end
      tick();
      checks++; if ({ex_valid_1, ex_valid_2, split_pending} !== 3'b000) begin
         errors++; $display("FAIL lu_bubble_flags got %b exp 000", {ex_valid_1, ex_valid_2, split_pending}); end
      ex_is_load = 1'b0; a_1 = 2'd0; b_1 = 2'd1; mem_result = 32'hDEAD;
      #1;
      checks++; if (id_ready !== 1'b1) begin
         errors++; $display("FAIL lu_id_ready_issue got %b exp 1", id_ready); end
      tick();
      checks++; if ({ex_valid_1, ex_op1_1} !== {1'b1, 32'hDEAD}) begin
         errors++; $display("FAIL lu_slot1_op got %b %h exp 1 dead", ex_valid_1, ex_op1_1); end
      drain();
      // Slot 2 load-use without a dependency also bubbles the whole bundle.
      id_valid = 1'b1; ex_is_load = 1'b1; a_2 = 2'd2;
      #1;
      checks++; if (id_ready !== 1'b0) begin
         errors++; $display("FAIL lu2_id_ready got %b exp 0", id_ready); end
      tick();
      checks++; if ({ex_valid_1, ex_valid_2} !== 2'b00) begin
         errors++; $display("FAIL lu2_bubble got %b exp 00", {ex_valid_1, ex_valid_2}); end
      drain();
   endtask

   task automatic test_priority();
      id_valid = 1'b1;
      a_1 = 2'd3; b_1 = 2'd3; c_1 = 2'd3;
      a_2 = 2'd0; b_2 = 2'd3; c_2 = 2'd3;
      ex_result = 32'h1111; mem_result = 32'h2222; wb_result = 32'h3333;
      tick();
      checks++; if ({ex_op1_1, ex_op2_1} !== {32'h1111, 32'h1111}) begin
         errors++; $display("FAIL prio_ex got %h %h exp 1111 1111", ex_op1_1, ex_op2_1); end
      checks++; if ({ex_op1_2, ex_op2_2} !== {32'h2222, 32'h2222}) begin
         errors++; $display("FAIL prio_mem got %h %h exp 2222 2222", ex_op1_2, ex_op2_2); end
      drain();
   endtask

   task automatic test_flush_split();
      id_valid = 1'b1; dst_1 = 5'd5; s1_2 = 5'd5;
      tick();
      checks++; if (split_pending !== 1'b1) begin
         errors++; $display("FAIL flush_pre_split got %b exp 1", split_pending); end
      flush = 1'b1;
      #1;
      checks++; if (id_ready !== 1'b1) begin
         errors++; $display("FAIL flush_id_ready got %b exp 1", id_ready); end
      tick();
      checks++; if ({ex_valid_1, ex_valid_2, split_pending} !== 3'b000) begin
         errors++; $display("FAIL flush_flags got %b exp 000", {ex_valid_1, ex_valid_2, split_pending}); end
      drain();
      checks++; if ({ex_valid_2, split_pending} !== 2'b00) begin
         errors++; $display("FAIL flush_no_slot2 got %b exp 00", {ex_valid_2, split_pending}); end
   endtask

   task automatic test_stall_reset();
      id_valid = 1'b1; rs1_1 = 32'h55; rs2_1 = 32'h56; rs1_2 = 32'h57; rs2_2 = 32'h58;
      tick();
      rs1_1 = 32'h66; rs2_1 = 32'h66; rs1_2 = 32'h66; rs2_2 = 32'h66;
      dst_1 = 5'd10; ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (id_ready !== 1'b0) begin
            errors++; $display("FAIL stall_id_ready[%0d] got %b exp 0", i, id_ready); end
         tick();
         checks++; if ({ex_valid_1, ex_valid_2, ex_op1_1, ex_op2_2, ex_dst_1} !==
                       {1'b1, 1'b1, 32'h55, 32'h58, 5'd1}) begin
            errors++; $display("FAIL stall_hold[%0d] got %b%b %h %h %0d exp 11 55 58 1",
                               i, ex_valid_1, ex_valid_2, ex_op1_1, ex_op2_2, ex_dst_1); end
      end
      #2;
      rst = 1'b1;
      #1;
      checks++; if ({ex_valid_1, ex_valid_2, split_pending} !== 3'b000) begin
         errors++; $display("FAIL async_rst_flags got %b exp 000", {ex_valid_1, ex_valid_2, split_pending}); end
      checks++; if ({ex_op1_1, ex_op2_1, ex_op1_2, ex_op2_2, ex_dst_1, ex_dst_2} !== 138'h0) begin
         errors++; $display("FAIL async_rst_data got nonzero exp 0"); end
      tick();
      rst = 1'b0;
      drain();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_independent();
      test_intra_dep();
      test_dst_zero();
      test_load_use();
      test_priority();
      test_flush_split();
      test_stall_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
